// File: rtl/shadow_chain_pattern_gen.sv
// Synthetic serial-chain source: NUM_CHAINS independent shifters emitting one of
// four deterministic patterns per dump, with per-chain stall, valid and done.
module shadow_chain_pattern_gen #(
    parameter int          NUM_CHAINS = 32,
    parameter int          CHAIN_LEN  = 64,
    parameter logic [15:0] TAG        = 16'hCDEF,
    parameter logic [31:0] LFSR_POLY  = 32'h80200003
) (
    input  logic                  sh_clk,
    input  logic                  sh_rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [31:0]           seed,
    input  logic [NUM_CHAINS-1:0] dump_en,
    output logic [NUM_CHAINS-1:0] ch_out,
    output logic [NUM_CHAINS-1:0] ch_out_vld,
    output logic [NUM_CHAINS-1:0] ch_out_done,
    output logic                  busy,
    output logic [7:0]            dump_seq
);

    typedef enum logic [1:0] {M_COUNT, M_LFSR, M_WALK, M_ALT} mode_e;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    localparam int            CW   = 11;
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    mode_e                  mode_l;
    logic [7:0]             seq_l;
    logic                   start_acc;
    logic [NUM_CHAINS-1:0]  shifting;

    function automatic logic [31:0] lfsr_init(input logic [31:0] sd, input logic [31:0] idx);
        logic [31:0] s;
        s = sd ^ idx;
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Done is folded in so busy stays high through the final bit's cycle.
    assign start_acc = start & ~busy;
    assign busy      = (|shifting) | (|ch_out_done);

    always_ff @(posedge sh_clk) begin
        if (sh_rst) begin
            dump_seq <= 8'd0;
        end else if (start_acc) begin
            dump_seq <= dump_seq + 8'd1;
        end
    end

    always_ff @(posedge sh_clk) begin
        if (start_acc) begin
            mode_l <= mode_e'(mode);
            seq_l  <= dump_seq;
        end
    end

    for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
        localparam logic [7:0]    CH_ID    = 8'(i);
        localparam logic [31:0]   CH_MASK  = 32'(i);
        localparam logic [CW-1:0] WALK_POS = CW'(i % CHAIN_LEN);

        state_e        st, st_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [31:0]   lfsr, lfsr_nxt;
        logic [31:0]   word;
        logic          pat_bit;
        logic          out_q, out_nxt;
        logic          vld_q, vld_nxt;
        logic          done_q, done_nxt;

        assign word = {TAG, CH_ID, seq_l};

        always_comb begin
            case (mode_l)
                M_COUNT: pat_bit = word[cnt[4:0]];
                M_LFSR:  pat_bit = lfsr[0];
                M_WALK:  pat_bit = (cnt == WALK_POS);
                default: pat_bit = ~cnt[0];
            endcase
        end

        always_comb begin
            st_nxt   = st;
            cnt_nxt  = cnt;
            lfsr_nxt = lfsr;
            out_nxt  = out_q;
            vld_nxt  = 1'b0;
            done_nxt = 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start_acc) begin
                        st_nxt   = ST_SHIFT;
                        cnt_nxt  = '0;
                        lfsr_nxt = lfsr_init(seed, CH_MASK);
                    end
                end
                default: begin
                    if (dump_en[i]) begin
                        out_nxt  = pat_bit;
                        vld_nxt  = 1'b1;
                        cnt_nxt  = cnt + 1'b1;
                        lfsr_nxt = lfsr_step(lfsr);
                        if (cnt == LAST) begin
                            done_nxt = 1'b1;
                            st_nxt   = ST_IDLE;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge sh_clk) begin
            if (sh_rst) begin
                st     <= ST_IDLE;
                out_q  <= 1'b0;
                vld_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                st     <= st_nxt;
                out_q  <= out_nxt;
                vld_q  <= vld_nxt;
                done_q <= done_nxt;
            end
        end

        // Counter and LFSR are reloaded on every accepted start.
        always_ff @(posedge sh_clk) begin
            cnt  <= cnt_nxt;
            lfsr <= lfsr_nxt;
        end

        assign ch_out[i]      = out_q;
        assign ch_out_vld[i]  = vld_q;
        assign ch_out_done[i] = done_q;
        assign shifting[i]    = (st == ST_SHIFT);
    end

endmodule

// File: tb/tb_shadow_chain_pattern_gen.sv
// Randomised bench for shadow_chain_pattern_gen: each dump is captured per chain
// and compared against a pattern model computed straight from the pattern rules.
module tb_shadow_chain_pattern_gen;

    localparam int          NC   = 4;
    localparam int          CL   = 32;
    localparam logic [31:0] POLY = 32'h80200003;

    logic          sh_clk = 1'b0;
    logic          sh_rst, start;
    logic [1:0]    mode;
    logic [31:0]   seed;
    logic [NC-1:0] dump_en, ch_out, ch_out_vld, ch_out_done;
    logic          busy;
    logic [7:0]    dump_seq;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_seq;

    logic [CL-1:0] got_word [NC];
    int            nvld [NC];
    int            ndone [NC];
    int            done_cyc [NC];
    int            done_nvld [NC];
    int            bad_vld;
    int            busy_drop;
    logic [7:0]    used_seq;
    logic [7:0]    seq_mid;

    shadow_chain_pattern_gen #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
        .sh_clk(sh_clk), .sh_rst(sh_rst), .start(start), .mode(mode), .seed(seed),
        .dump_en(dump_en), .ch_out(ch_out), .ch_out_vld(ch_out_vld),
        .ch_out_done(ch_out_done), .busy(busy), .dump_seq(dump_seq)
    );

    always #5 sh_clk = ~sh_clk;

    function automatic logic [CL-1:0] model_word(input int ch, input logic [1:0] md,
                                                 input logic [31:0] sd, input logic [7:0] sq);
        logic [31:0] w, s;
        logic [CL-1:0] r;
        w = {16'hCDEF, 8'(ch), sq};
        s = sd ^ 32'(ch);
        if (s == 32'h0) s = 32'h1;
        for (int k = 0; k < CL; k++) begin
            case (md)
                2'd0: r[k] = w[k % 32];
                2'd1: begin
                    r[k] = s[0];
                    s = (s >> 1) ^ (s[0] ? POLY : 32'h0);
                end
                2'd2: r[k] = (k == ch % CL);
                default: r[k] = (k % 2 == 0);
            endcase
        end
        return r;
    endfunction

    // en_kind: 0 all enabled, 1 random per chain, 2 chain 1 toggles every cycle.
    task automatic run_dump(input logic [1:0] md, input logic [31:0] sd, input int en_kind, input bit poke);
        logic [NC-1:0] prev_en;
        for (int ch = 0; ch < NC; ch++) begin
            got_word[ch] = '0; nvld[ch] = 0; ndone[ch] = 0; done_cyc[ch] = -1; done_nvld[ch] = -1;
        end
        bad_vld = 0; busy_drop = -1; seq_mid = 8'hxx;
        start = 1'b1; mode = md; seed = sd; dump_en = '1;
        used_seq = exp_seq;
        @(negedge sh_clk);
        start = 1'b0;
        exp_seq = exp_seq + 8'd1;
        prev_en = '0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge sh_clk);
            for (int ch = 0; ch < NC; ch++) begin
                if (ch_out_vld[ch] && !prev_en[ch]) bad_vld++;
                if (ch_out_vld[ch]) begin
                    if (nvld[ch] < CL) got_word[ch][nvld[ch]] = ch_out[ch];
                    nvld[ch]++;
                end
                if (ch_out_done[ch]) begin
                    ndone[ch]++; done_cyc[ch] = c; done_nvld[ch] = nvld[ch];
                    if (!ch_out_vld[ch]) bad_vld++;
                end
            end
            if (poke && c == 7) seq_mid = dump_seq;
            if (!busy) begin
                busy_drop = c;
                break;
            end
            for (int ch = 0; ch < NC; ch++) begin
                case (en_kind)
                    0: dump_en[ch] = 1'b1;
                    1: dump_en[ch] = ($urandom_range(3) != 0);
                    default: dump_en[ch] = (ch == 1) ? (c % 2 == 0) : 1'b1;
                endcase
            end
            start = poke && (c == 4);
            mode  = (poke && c == 4) ? ~md : md;
            prev_en = dump_en;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        sh_rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'h0; dump_en = '0;
        repeat (3) @(negedge sh_clk);
        sh_rst = 1'b0;
        checks++;
        if (ch_out !== '0 || ch_out_vld !== '0 || ch_out_done !== '0 || busy !== 1'b0 || dump_seq !== 8'd0) begin
            errors++;
            $display("FAIL reset_state out=%b vld=%b done=%b busy=%b seq=%0d, want all 0",
                     ch_out, ch_out_vld, ch_out_done, busy, dump_seq);
        end
        start = 1'b1; mode = 2'd3; dump_en = '1;
        @(negedge sh_clk);
        start = 1'b0;
        repeat (10) @(negedge sh_clk);
        sh_rst = 1'b1;
        @(negedge sh_clk);
        sh_rst = 1'b0;
        checks++;
        if (ch_out !== '0 || ch_out_vld !== '0 || ch_out_done !== '0 || busy !== 1'b0 || dump_seq !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_dump out=%b vld=%b done=%b busy=%b seq=%0d, want all 0",
                     ch_out, ch_out_vld, ch_out_done, busy, dump_seq);
        end
        exp_seq = 8'd0;
        run_dump(2'd0, 32'h0, 0, 1'b0);
        checks++;
        if (got_word[2] !== 32'hCDEF0200 || nvld[2] != CL || done_nvld[2] != CL) begin
            errors++;
            $display("FAIL reset_restart chain2 got=%h nvld=%0d done_at=%0d, want CDEF0200 32 32",
                     got_word[2], nvld[2], done_nvld[2]);
        end
        checks++;
        if (dump_seq !== 8'd1) begin
            errors++;
            $display("FAIL reset_restart_seq got=%0d want 1", dump_seq);
        end
    endtask

    task automatic test_count();
        run_dump(2'd0, $urandom, 0, 1'b0);
        checks++;
        if (got_word[2] !== 32'hCDEF0201) begin
            errors++;
            $display("FAIL count_chain2 got=%h want CDEF0201", got_word[2]);
        end
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (got_word[ch] !== model_word(ch, 2'd0, 32'h0, used_seq) || nvld[ch] != CL ||
                ndone[ch] != 1 || done_nvld[ch] != CL || done_cyc[ch] != CL + 1) begin
                errors++;
                $display("FAIL count_chain ch=%0d got=%h nvld=%0d ndone=%0d done_cyc=%0d want=%h %0d 1 %0d",
                         ch, got_word[ch], nvld[ch], ndone[ch], done_cyc[ch],
                         model_word(ch, 2'd0, 32'h0, used_seq), CL, CL + 1);
            end
        end
        checks++;
        if (busy_drop != CL + 2 || dump_seq !== exp_seq) begin
            errors++;
            $display("FAIL count_busy_seq busy_drop=%0d seq=%0d want %0d %0d", busy_drop, dump_seq, CL + 2, exp_seq);
        end
    endtask

    task automatic test_lfsr();
        logic [CL-1:0] first0;
        run_dump(2'd1, 32'h1, 0, 1'b0);
        first0 = got_word[0];
        checks++;
        if (got_word[0][2:0] !== 3'b011) begin
            errors++;
            $display("FAIL lfsr_first_bits got=%b want 011", got_word[0][2:0]);
        end
        run_dump(2'd1, 32'h0, 0, 1'b0);
        checks++;
        if (got_word[0] !== first0 || got_word[0] !== model_word(0, 2'd1, 32'h1, 8'd0)) begin
            errors++;
            $display("FAIL lfsr_zero_seed got=%h want=%h", got_word[0], model_word(0, 2'd1, 32'h1, 8'd0));
        end
        for (int r = 0; r < 3; r++) begin
            logic [31:0] sd;
            sd = $urandom;
            run_dump(2'd1, sd, 1, 1'b0);
            for (int ch = 0; ch < NC; ch++) begin
                checks++;
                if (got_word[ch] !== model_word(ch, 2'd1, sd, used_seq) || nvld[ch] != CL ||
                    ndone[ch] != 1 || done_nvld[ch] != CL) begin
                    errors++;
                    $display("FAIL lfsr_random seed=%h ch=%0d got=%h nvld=%0d ndone=%0d want=%h",
                             sd, ch, got_word[ch], nvld[ch], ndone[ch], model_word(ch, 2'd1, sd, used_seq));
                end
            end
            checks++;
            if (bad_vld != 0) begin
                errors++;
                $display("FAIL lfsr_stall_vld bad=%0d want 0", bad_vld);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  md;
        logic [31:0] sd;
        int          lag;
        md = 2'($urandom_range(3));
        sd = $urandom;
        run_dump(md, sd, 2, 1'b0);
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (got_word[ch] !== model_word(ch, md, sd, used_seq) || nvld[ch] != CL || done_nvld[ch] != CL) begin
                errors++;
                $display("FAIL bp_chain mode=%0d ch=%0d got=%h nvld=%0d want=%h",
                         md, ch, got_word[ch], nvld[ch], model_word(ch, md, sd, used_seq));
            end
        end
        lag = done_cyc[1] - done_cyc[0];
        checks++;
        if (lag < 30 || lag > 33 || busy_drop != done_cyc[1] + 1 || bad_vld != 0) begin
            errors++;
            $display("FAIL bp_timing lag=%0d busy_drop=%0d bad_vld=%0d want lag 30..33 drop %0d bad 0",
                     lag, busy_drop, bad_vld, done_cyc[1] + 1);
        end
    endtask

    task automatic test_walk_alt();
        run_dump(2'd2, $urandom, 1, 1'b0);
        checks++;
        if (got_word[3] !== 32'h8 || $countones(got_word[3]) != 1) begin
            errors++;
            $display("FAIL walk_chain3 got=%h want 00000008", got_word[3]);
        end
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (got_word[ch] !== model_word(ch, 2'd2, 32'h0, used_seq)) begin
                errors++;
                $display("FAIL walk_chain ch=%0d got=%h want=%h", ch, got_word[ch], model_word(ch, 2'd2, 32'h0, used_seq));
            end
        end
        run_dump(2'd3, $urandom, 1, 1'b0);
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (got_word[ch] !== 32'h55555555 || done_nvld[ch] != CL || ndone[ch] != 1) begin
                errors++;
                $display("FAIL alt_chain ch=%0d got=%h done_at=%0d ndone=%0d want 55555555 %0d 1",
                         ch, got_word[ch], done_nvld[ch], ndone[ch], CL);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_dump(2'd0, $urandom, 0, 1'b1);
        checks++;
        if (seq_mid !== used_seq + 8'd1 || dump_seq !== exp_seq) begin
            errors++;
            $display("FAIL busy_start_seq mid=%0d end=%0d want %0d", seq_mid, dump_seq, exp_seq);
        end
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (got_word[ch] !== model_word(ch, 2'd0, 32'h0, used_seq) || ndone[ch] != 1) begin
                errors++;
                $display("FAIL busy_start_word ch=%0d got=%h want=%h", ch, got_word[ch], model_word(ch, 2'd0, 32'h0, used_seq));
            end
        end
    endtask

    task automatic test_wrap();
        while (exp_seq != 8'd0) begin
            run_dump(2'($urandom_range(3)), $urandom, 0, 1'b0);
            checks++;
            if (dump_seq !== exp_seq) begin
                errors++;
                $display("FAIL wrap_seq got=%0d want %0d", dump_seq, exp_seq);
            end
        end
        checks++;
        if (dump_seq !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero got=%0d want 0", dump_seq);
        end
        run_dump(2'd0, 32'h0, 0, 1'b0);
        checks++;
        if (got_word[2] !== 32'hCDEF0200 || dump_seq !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count_word got=%h seq=%0d want CDEF0200 1", got_word[2], dump_seq);
        end
    endtask

    initial begin
        exp_seq = 8'd0;
        test_reset();
        test_count();
        test_lfsr();
        test_backpressure();
        test_walk_alt();
        test_start_while_busy();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shadow_chain_pattern_gen.md
Name: shadow_chain_pattern_gen

Overview:
Parametrised synthetic chain source for bringing up and verifying shadow_capture without a real core. It drives NUM_CHAINS serial chains, one bit per chain per cycle, with per-chain valid and done and per-chain dump_en back-pressure. It supports four selectable deterministic patterns and a dump sequence number. It sits in front of shadow_capture's chains_in, chains_in_vld and chains_in_done inputs in dummy core wrappers.

Parameters:
NUM_CHAINS, 32, number of serial chains (1..256).
CHAIN_LEN, 64, bits shifted per chain per dump (2..1024).
TAG, 16'hCDEF, constant tag embedded in COUNT-mode words.
LFSR_POLY, 32'h80200003, Galois feedback mask for LFSR mode.

Ports:
sh_clk  in  1  shadow/data clock; all logic on its rising edge.
sh_rst  in  1  synchronous active-high reset.
start  in  1  arm all chains for one dump; accepted only when busy=0.
mode  in  2  pattern select, sampled on accepted start: 0 COUNT, 1 LFSR, 2 WALK, 3 ALT.
seed  in  32  LFSR seed, sampled on accepted start.
dump_en  in  NUM_CHAINS  per-chain shift enable (stall when 0).
ch_out  out  NUM_CHAINS  serial chain data.
ch_out_vld  out  NUM_CHAINS  ch_out[i] is valid this cycle.
ch_out_done  out  NUM_CHAINS  final bit of chain i is being presented this cycle.
busy  out  1  OR of all chains not IDLE.
dump_seq  out  8  count of accepted starts, modulo 256.

Behaviour:
- Reset (sh_rst=1 at a clock edge): ch_out=0, ch_out_vld=0, ch_out_done=0, dump_seq=0, all chains IDLE, busy=0. Reset mid-dump aborts every chain immediately; no done is issued.
- Accepted start (start=1, busy=0):
  - Latch mode; latch seq_l = dump_seq; dump_seq increments (255 wraps to 0).
  - Every chain goes IDLE to SHIFT with bit counter cnt=0.
  - busy=1 from the next cycle.
- start while busy=1 is ignored: no latch, no dump_seq change.
- Per-chain FSM: IDLE, then SHIFT, then back to IDLE. Chains run independently.
- In SHIFT, at each edge:
  - If dump_en[i]=1: ch_out[i] <= bit(i,cnt); ch_out_vld[i] <= 1; cnt++.
  - If dump_en[i]=0: ch_out_vld[i] <= 0; ch_out[i] holds; cnt holds; LFSR holds.
- Done: when the bit at cnt=CHAIN_LEN-1 is presented, ch_out_done[i]=1 in the same cycle as its vld (one-cycle pulse), and the chain returns to IDLE.
- In IDLE: ch_out_vld[i]=0, ch_out_done[i]=0, ch_out[i] holds.
- Output latency: one cycle from dump_en[i] sampled high to the registered bit.
- Pattern bit(i,cnt):
  - COUNT: W = {TAG, i[7:0], seq_l}, 32 bits. bit = W[cnt mod 32], LSB first, repeating every 32 bits.
  - LFSR: per-chain state s initialised at start to seed ^ i (zero-extended i); a zero result is replaced by 32'h1. bit = s[0]. On each shift, s <= {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 0).
  - WALK: bit = (cnt == i mod CHAIN_LEN).
  - ALT: bit = ~cnt[0], giving 1,0,1,0...
- busy deasserts in the cycle after the last chain's done cycle.
- A new start is accepted in that same cycle or later.

Test Plan:
- Reset: NUM_CHAINS=4, CHAIN_LEN=32; assert sh_rst mid-dump -> next cycle all outputs 0, busy=0, dump_seq=0; a subsequent start begins at cnt=0.
- COUNT: start with mode=0, all dump_en=1 -> chain 2 emits 0xCDEF0200 LSB first (bit9=1, bits16..31=CDEF); done on cycle 32 after start+1; dump_seq=1. Second dump: chain 2 word = 0xCDEF0201.
- LFSR: mode=1, seed=1 -> chain 0 bits are 1,1,0 (states 0x00000001, 0x80200003, 0xC0300002). seed=0 on chain 0 uses state 32'h1.
- Back-pressure: toggle dump_en[1] every cycle -> vld[1] pulses only on enabled cycles; 32 valid bits with the same sequence as unstalled; done[1] lags chain 0 by about 31 cycles; busy holds until then.
- WALK and ALT: mode=2 -> chain 3 has exactly one 1, at bit 3. mode=3 -> 1010... with done on the 32nd valid bit.
- start while busy, and wrap: pulse start mid-dump -> ignored, dump_seq unchanged. 256 dumps -> dump_seq wraps to 0, and the COUNT word seq byte follows it.
